// File: rtl/apcpu_stack_pkg.sv
// Shared stack definitions for the APCPU: op codes, SP drive
// commands, sequencer states and default stack geometry.
package apcpu_stack_pkg;

  localparam logic [31:0] STACK_BASE_DEF  = 32'h0000_1000;
  localparam int unsigned STACK_DEPTH_DEF = 256;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_SET  = 2'b10,
    OP_PEEK = 2'b11
  } op_e;

  // Also decoded by the SP register itself
  typedef enum logic [1:0] {
    SP_HOLD = 2'b00,
    SP_INC  = 2'b01,
    SP_DEC  = 2'b10,
    SP_LOAD = 2'b11
  } sp_drive_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_POP_RD,
    S_RD_WAIT,
    S_SET,
    S_RESP
  } state_e;

endpackage

// File: rtl/stack_ctrl.sv
// Stack access sequencer: push/pop/set/peek to memory + SP commands.
// STACK_CTRL_PEEK_EN enables op 11 (peek); otherwise it errors.
module stack_ctrl
  import apcpu_stack_pkg::*;
#(
  parameter logic [31:0] STACK_BASE  = STACK_BASE_DEF,
  parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  input  logic [31:0] sp_value,
  output logic [1:0]  sp_drive,
  output logic [31:0] sp_set,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] DEPTH32 = 32'(STACK_DEPTH);

  state_e      state, nxt;
  op_e         op_q;
  logic [31:0] data_q;
  logic [31:0] sp_q;
  logic        rdy_q;
  logic        acc;
  logic        err_c;

  assign acc       = req_valid && rdy_q;
  assign req_ready = rdy_q;
  assign rsp_valid = (state == S_RESP);

  always_comb begin
    err_c = 1'b0;
    unique case (req_op)
      OP_PUSH: err_c = (sp_value == DEPTH32);
      OP_POP:  err_c = (sp_value == '0);
      OP_SET:  err_c = (req_data > DEPTH32);
      OP_PEEK: begin
`ifdef STACK_CTRL_PEEK_EN
        err_c = (sp_value == '0);
`else
        err_c = 1'b1;
`endif
      end
      default: err_c = 1'b1;
    endcase
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: begin
        if (acc) begin
          if (err_c)                  nxt = S_RESP;
          else if (req_op == OP_PUSH) nxt = S_PUSH;
          else if (req_op == OP_SET)  nxt = S_SET;
          else                        nxt = S_POP_RD;
        end
      end
      S_PUSH:    nxt = S_RESP;
      S_SET:     nxt = S_RESP;
      S_POP_RD:  nxt = S_RD_WAIT;
      S_RD_WAIT: nxt = S_RESP;
      S_RESP:    if (rsp_ready) nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  // Strobes decode from state only, so reset kills them at once
  always_comb begin
    sp_drive  = SP_HOLD;
    sp_set    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    unique case (state)
      S_PUSH: begin
        mem_we    = 1'b1;
        mem_addr  = STACK_BASE + sp_q;
        mem_wdata = data_q;
        sp_drive  = SP_INC;
      end
      S_POP_RD: begin
        mem_re   = 1'b1;
        mem_addr = STACK_BASE + sp_q - 32'd1;
        if (op_q == OP_POP) sp_drive = SP_DEC;
      end
      S_SET: begin
        sp_drive = SP_LOAD;
        sp_set   = data_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      rdy_q    <= 1'b0;
      op_q     <= OP_PUSH;
      data_q   <= '0;
      sp_q     <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state <= nxt;
      rdy_q <= (nxt == S_IDLE);
      if (acc) begin
        op_q     <= op_e'(req_op);
        data_q   <= req_data;
        sp_q     <= sp_value;
        rsp_err  <= err_c;
        rsp_data <= (!err_c && req_op == OP_SET) ? req_data : '0;
      end else if (state == S_RD_WAIT) begin
        rsp_data <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: vector table, corner sequences, and random
// ops against a plain array/counter stack model.
module tb_stack_ctrl;
  import apcpu_stack_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sp_rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] sp_value;
  logic [1:0]  sp_drive;
  logic [31:0] sp_set;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stack_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .sp_value(sp_value), .sp_drive(sp_drive), .sp_set(sp_set),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  // External SP register and word memory
  logic [31:0] sp_reg = '0;
  logic [31:0] mem [0:511];
  logic [31:0] off;
  int we_cnt = 0;
  int re_cnt = 0;

  assign sp_value = sp_reg;
  assign off = mem_addr - BASE;

  initial for (int i = 0; i < 512; i++) mem[i] = '0;

  always @(posedge clk) begin
    if (sp_rst) sp_reg <= '0;
    else case (sp_drive)
      2'b01: sp_reg <= sp_reg + 32'd1;
      2'b10: sp_reg <= sp_reg - 32'd1;
      2'b11: sp_reg <= sp_set;
      default: ;
    endcase
    if (mem_we) begin
      mem[off[8:0]] <= mem_wdata;
      we_cnt <= we_cnt + 1;
    end
    if (mem_re) begin
      mem_rdata <= mem[off[8:0]];
      re_cnt <= re_cnt + 1;
    end else begin
      mem_rdata <= 32'hBAD0_BAD0;
    end
  end

  // Reference model: the stack as an array plus a depth count
  int          m_sp = 0;
  logic [31:0] m_mem [0:DEPTH];
  initial for (int i = 0; i <= DEPTH; i++) m_mem[i] = '0;

  task automatic model_op(input logic [1:0] op, input logic [31:0] d,
                          output logic [31:0] ed, output logic ee,
                          output int el, output int ea);
    ed = '0; ee = 1'b1; el = 1; ea = 0;
    case (op)
      2'b00: if (m_sp < DEPTH) begin
        m_mem[m_sp] = d; m_sp++; ee = 1'b0; el = 2; ea = 1;
      end
      2'b01: if (m_sp > 0) begin
        m_sp--; ed = m_mem[m_sp]; ee = 1'b0; el = 3; ea = 1;
      end
      2'b10: if (d <= 32'(DEPTH)) begin
        m_sp = int'(d); ed = d; ee = 1'b0; el = 2;
      end
      default: begin
`ifdef STACK_CTRL_PEEK_EN
        if (m_sp > 0) begin
          ed = m_mem[m_sp-1]; ee = 1'b0; el = 3; ea = 1;
        end
`endif
      end
    endcase
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one request from a negedge; returns at the negedge after
  // the response handshake.
  task automatic run_op(input logic [1:0] op, input logic [31:0] d,
                        input int hold,
                        output logic [31:0] rd, output logic re,
                        output int lat, output int acc,
                        output logic [1:0] drv, output logic [31:0] addr);
    int n, we0, re0;
    we0 = we_cnt; re0 = re_cnt;
    req_op = op; req_data = d; req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk); n++;
    end
    if (n >= 20) chk("accept_timeout", 32'(n), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    drv = sp_drive; addr = mem_addr;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 10) begin
      @(negedge clk); lat++;
    end
    rd = rsp_data; re = rsp_err;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_op = 2'b10; req_data = 32'd5;
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_data", rsp_data, rd);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    acc = (we_cnt - we0) + (re_cnt - re0);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] d;
    logic        err;
    logic [31:0] data;
    int          lat;
    int          acc;
    logic [1:0]  drv;
    int          sp;
  } vec_t;

  vec_t        tbl [14];
  logic [31:0] rd, ed;
  logic        re, ee;
  int          lat, acc, el, ea;
  logic [1:0]  drv;
  logic [31:0] addr;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{2'b01, 32'h0,        1'b1, 32'h0,        1, 0, 2'd0, 0};
    tbl[1]  = '{2'b10, 32'h100,      1'b0, 32'h100,      2, 0, 2'd3, 256};
    tbl[2]  = '{2'b00, 32'h1234,     1'b1, 32'h0,        1, 0, 2'd0, 256};
    tbl[3]  = '{2'b10, 32'h101,      1'b1, 32'h0,        1, 0, 2'd0, 256};
    tbl[4]  = '{2'b10, 32'h80,       1'b0, 32'h80,       2, 0, 2'd3, 128};
    tbl[5]  = '{2'b00, 32'hA5A5A5A5, 1'b0, 32'h0,        2, 1, 2'd1, 129};
    tbl[6]  = '{2'b00, 32'h5A5A0001, 1'b0, 32'h0,        2, 1, 2'd1, 130};
`ifdef STACK_CTRL_PEEK_EN
    tbl[7]  = '{2'b11, 32'h0,        1'b0, 32'h5A5A0001, 3, 1, 2'd0, 130};
`else
    tbl[7]  = '{2'b11, 32'h0,        1'b1, 32'h0,        1, 0, 2'd0, 130};
`endif
    tbl[8]  = '{2'b01, 32'h0,        1'b0, 32'h5A5A0001, 3, 1, 2'd2, 129};
    tbl[9]  = '{2'b01, 32'h0,        1'b0, 32'hA5A5A5A5, 3, 1, 2'd2, 128};
    tbl[10] = '{2'b10, 32'h0,        1'b0, 32'h0,        2, 0, 2'd3, 0};
    tbl[11] = '{2'b11, 32'h0,        1'b1, 32'h0,        1, 0, 2'd0, 0};
    tbl[12] = '{2'b10, 32'h1,        1'b0, 32'h1,        2, 0, 2'd3, 1};
    tbl[13] = '{2'b01, 32'h0,        1'b0, 32'hDEADBEEF, 3, 1, 2'd2, 0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_sp_drive", 32'(sp_drive), 32'd0);
    chk("rst_sp_set", sp_set, 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0; sp_rst = 1'b0;
    @(negedge clk);
    chk("req_ready_after_rst", 32'(req_ready), 32'd1);

    // First push and pop
    model_op(2'b00, 32'hDEADBEEF, ed, ee, el, ea);
    run_op(2'b00, 32'hDEADBEEF, 0, rd, re, lat, acc, drv, addr);
    chk("push1_drive", 32'(drv), 32'd1);
    chk("push1_addr", addr, 32'h1000);
    chk("push1_lat", 32'(lat), 32'd2);
    chk("push1_err", 32'(re), 32'd0);
    chk("push1_we", 32'(acc), 32'd1);
    chk("push1_sp", sp_reg, 32'd1);
    model_op(2'b01, 32'h0, ed, ee, el, ea);
    run_op(2'b01, 32'h0, 0, rd, re, lat, acc, drv, addr);
    chk("pop1_drive", 32'(drv), 32'd2);
    chk("pop1_addr", addr, 32'h1000);
    chk("pop1_lat", 32'(lat), 32'd3);
    chk("pop1_data", rd, 32'hDEADBEEF);
    chk("pop1_sp", sp_reg, 32'd0);

    // Vector table
    foreach (tbl[i]) begin
      model_op(tbl[i].op, tbl[i].d, ed, ee, el, ea);
      run_op(tbl[i].op, tbl[i].d, 0, rd, re, lat, acc, drv, addr);
      chk($sformatf("tbl%0d_err", i), 32'(re), 32'(tbl[i].err));
      chk($sformatf("tbl%0d_data", i), rd, tbl[i].data);
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("tbl%0d_mem", i), 32'(acc), 32'(tbl[i].acc));
      chk($sformatf("tbl%0d_drv", i), 32'(drv), 32'(tbl[i].drv));
      chk($sformatf("tbl%0d_sp", i), sp_reg, 32'(tbl[i].sp));
    end

    // Response held for 5 cycles while another request waits
    model_op(2'b00, 32'h77, ed, ee, el, ea);
    run_op(2'b00, 32'h77, 5, rd, re, lat, acc, drv, addr);
    chk("hold_err", 32'(re), 32'd0);
    chk("hold_sp", sp_reg, 32'd1);

    // Reset during POP_RD
    req_op = 2'b01; req_data = '0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_mem_re_before", 32'(mem_re), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort_mem_re", 32'(mem_re), 32'd0);
    chk("abort_sp_drive", 32'(sp_drive), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_idle", 32'(req_ready), 32'd1);
    chk("abort_sp", sp_reg, 32'd1);

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      logic [1:0]  op;
      logic [31:0] d;
      op = 2'($urandom_range(0, 3));
      d  = $urandom;
      if (op == 2'b10)
        d = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(250, 260))
                                        : 32'($urandom_range(0, 8));
      model_op(op, d, ed, ee, el, ea);
      run_op(op, d, $urandom_range(0, 2), rd, re, lat, acc, drv, addr);
      chk($sformatf("rnd%0d_err", k), 32'(re), 32'(ee));
      chk($sformatf("rnd%0d_data", k), rd, ed);
      chk($sformatf("rnd%0d_lat", k), 32'(lat), 32'(el));
      chk($sformatf("rnd%0d_mem", k), 32'(acc), 32'(ea));
      chk($sformatf("rnd%0d_sp", k), sp_reg, 32'(m_sp));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
